// File: rtl/multibyte_add_seq.sv
// Byte-serial wide add/subtract sequencer driving one external 8-bit adder.
// Operands are latched on start; one byte is processed per cycle, LSB first,
// and the full-width result, carry-out and signed overflow are reported with
// a one-cycle done pulse.
module multibyte_add_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  ovf,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [7:0]      a_byte;
  logic [7:0]      b_byte;

  // Current operand bytes selected by the byte index.
  always_comb begin
    a_byte = a_q[{idx_q, 3'b000} +: 8];
    b_byte = b_q[{idx_q, 3'b000} +: 8];
  end

  // Next-state, datapath updates and adder/handshake outputs.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    busy     = 1'b0;
    done     = 1'b0;
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          a_d      = op_a;
          // Subtraction is A + ~B + 1, so B is stored pre-inverted.
          b_d      = sub ? ~op_b : op_b;
          carry_d  = sub | cin;
          idx_d    = '0;
          result_d = '0;
        end
      end
      RUN: begin
        busy    = 1'b1;
        add_a   = a_byte;
        add_b   = b_byte;
        add_cin = carry_q;
        result_d[{idx_q, 3'b000} +: 8] = add_sum;
        carry_d = add_cout;
        if (idx_q == LAST) begin
          state_d = DONE;
          cout_d  = add_cout;
          ovf_d   = (a_byte[7] == b_byte[7]) && (add_sum[7] != a_byte[7]);
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything, aborting any run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Scoreboard bench for multibyte_add_seq with a behavioural 8-bit adder.
module tb_multibyte_add_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          sub = 1'b0;
  logic          cin = 1'b0;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic          busy, done, cout, ovf;
  logic [W-1:0]  result;
  logic [7:0]    add_a, add_b, add_sum;
  logic          add_cin, add_cout;

  multibyte_add_seq #(.NBYTES(NB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .cin      (cin),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .ovf      (ovf),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // External ripple adder stand-in.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    int           sc;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  bit   prev_done = 1'b0;
  bit   b2b_mode = 1'b0;
  bit   have_acc = 1'b0;
  int   last_acc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic c, input int sc);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + (W+1)'(s | c);
    e.res = full[W-1:0];
    e.co  = full[W];
    e.ov  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    e.sc  = sc;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Accept monitor: sampled late in the low phase, just before the edge.
  always begin
    @(negedge clk);
    #3;
    if (rst_n && start && !busy) begin
      sbq.push_back(model(op_a, op_b, sub, cin, cyc + 1));
      if (b2b_mode && have_acc) chk("b2b_gap", 64'(cyc + 1 - last_acc), 64'(NB + 2));
      have_acc = 1'b1;
      last_acc = cyc + 1;
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      chk("done_twice", 64'(prev_done), 64'(0));
      if (sbq.size() == 0) begin
        chk("spurious_done", 64'(1), 64'(0));
      end else begin
        e = sbq.pop_front();
        chk("result", 64'(result), 64'(e.res));
        chk("cout", 64'(cout), 64'(e.co));
        chk("ovf", 64'(ovf), 64'(e.ov));
        chk("latency", 64'(cyc - e.sc), 64'(NB));
      end
      done_cnt++;
    end
    prev_done = done;
  end

  task automatic wait_idle();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_seen", 64'(busy), 64'(0));
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic c);
    wait_idle();
    op_a  = a;
    op_b  = b;
    sub   = s;
    cin   = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(1));
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int k = 0; k < budget && done_cnt < target; k++) begin
      @(negedge clk);
      #2;
    end
    chk("done_seen", 64'(done_cnt >= target), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d;
    int exp_cin[4] = '{0, 1, 0, 0};

    // Reset state
    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_add_a", 64'(add_a), 64'(0));
    chk("rst_add_b", 64'(add_b), 64'(0));
    chk("rst_add_cin", 64'(add_cin), 64'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Carry ripple across byte 0 -> 1
    d = done_cnt;
    issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("add_cin_seq", 64'(add_cin), 64'(exp_cin[i]));
    end
    wait_done(d + 1, 20);
    chk("t1_result", 64'(result), 64'h100);

    // Full wrap with carry-in
    d = done_cnt;
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
    wait_done(d + 1, 20);
    chk("t2_result", 64'(result), 64'h0);
    chk("t2_cout", 64'(cout), 64'(1));

    // Subtract with borrow
    d = done_cnt;
    issue(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
    wait_done(d + 1, 20);
    chk("t3_result", 64'(result), 64'hFFFF_FFFE);
    chk("t3_cout", 64'(cout), 64'(0));

    // Subtract with signed overflow; cin must be ignored
    d = done_cnt;
    issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
    wait_done(d + 1, 20);
    chk("t4_result", 64'(result), 64'h7FFF_FFFF);
    chk("t4_ovf", 64'(ovf), 64'(1));

    // Add with signed overflow, plus a start pulse during RUN
    d = done_cnt;
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    op_a  = 32'h1111_1111;
    op_b  = 32'h2222_2222;
    start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    wait_done(d + 1, 20);
    repeat (8) @(negedge clk);
    chk("one_done", 64'(done_cnt - d), 64'(1));
    chk("t5_result", 64'(result), 64'h8000_0000);
    chk("t5_ovf", 64'(ovf), 64'(1));

    // Reset during the second RUN cycle
    issue(32'h0000_00AA, 32'h0000_0011, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    d = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_result", 64'(result), 64'(0));
    chk("arst_add_a", 64'(add_a), 64'(0));
    chk("arst_add_b", 64'(add_b), 64'(0));
    chk("arst_add_cin", 64'(add_cin), 64'(0));
    sbq.delete();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    chk("arst_no_done", 64'(done_cnt - d), 64'(0));
    d = done_cnt;
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_done(d + 1, 20);
    chk("t6_result", 64'(result), 64'h2345_6789);

    // Back-to-back with start held high
    wait_idle();
    d = done_cnt;
    b2b_mode = 1'b1;
    have_acc = 1'b0;
    op_a  = 32'h0102_0304;
    op_b  = 32'h0F0F_0F0F;
    sub   = 1'b1;
    cin   = 1'b0;
    start = 1'b1;
    wait_done(d + 4, 40);
    start = 1'b0;
    b2b_mode = 1'b0;

    // Random operations
    for (int i = 0; i < 6; i++) begin
      d = done_cnt;
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_done(d + 1, 20);
    end

    repeat (10) @(negedge clk);
    chk("sb_drain", 64'(sbq.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
